// File: rtl/data_memory_hs_if.sv
// data_memory_hs_if: valid/ready request and registered response bundle for data_memory_hs (master = MEM stage, slave = memory)
interface data_memory_hs_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/data_memory_hs.sv
// data_memory_hs: handshaked RV32I byte/half/word data memory; ports clk, rst, bus (slave: req valid/ready/we/funct3/addr/wdata, resp valid/rdata/fault)
module data_memory_hs #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst,
  data_memory_hs_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state, nxt;
  logic [31:0] mem [DEPTH_WORDS];
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  cnt;
  logic        ready_q, rv_q, fault_q;
  logic [31:0] rdata_q;
  logic        accept, go, s_we, fault;
  logic [2:0]  s_f3;
  logic [31:0] s_addr, s_wdata, word, ld, wd;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [7:0]  bv;
  logic [15:0] hv;
  assign accept = bus.req_valid & ready_q;
  assign go = state == WAIT ? cnt == 4'd1 : accept && WAIT_STATES == 0;
  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
  // With no wait states the access happens on the accept edge itself, so the live request is decoded.
  always_comb begin
    s_we    = WAIT_STATES == 0 ? bus.req_we : we_q;
    s_f3    = WAIT_STATES == 0 ? bus.req_funct3 : f3_q;
    s_addr  = WAIT_STATES == 0 ? bus.req_addr : addr_q;
    s_wdata = WAIT_STATES == 0 ? bus.req_wdata : wdata_q;
    idx     = s_addr[AW+1:2];
    word    = mem[idx];
    bv      = 8'(word >> {s_addr[1:0], 3'b000});
    hv      = s_addr[1] ? word[31:16] : word[15:0];
    ld      = s_f3[1:0] == 2'b00 ? {{24{~s_f3[2] & bv[7]}}, bv} :
              s_f3[1:0] == 2'b01 ? {{16{~s_f3[2] & hv[15]}}, hv} : word;
    fault   = (s_f3[1:0] == 2'b01 && s_addr[0]) || (s_f3[1:0] == 2'b10 && |s_addr[1:0]) ||
              (s_we ? s_f3 > 3'd2 : s_f3 == 3'd3 || s_f3[2:1] == 2'b11) || |(s_addr >> (AW + 2));
    be      = s_f3[1:0] == 2'b00 ? 4'b0001 << s_addr[1:0] :
              s_f3[1:0] == 2'b01 ? (s_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd      = s_f3[1:0] == 2'b00 ? {4{s_wdata[7:0]}} :
              s_f3[1:0] == 2'b01 ? {2{s_wdata[15:0]}} : s_wdata;
    nxt     = go ? RESP : (accept || state == WAIT) ? WAIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      rv_q    <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= nxt;
      ready_q <= nxt != WAIT;
      rv_q    <= go;
      cnt     <= accept ? 4'(WAIT_STATES) : cnt - {3'b000, state == WAIT};
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (go) begin
        fault_q <= fault;
        rdata_q <= (fault || s_we) ? '0 : ld;
      end
    end
  end
  // Reset on the commit edge wins, so an interrupted store never lands.
  always_ff @(posedge clk) begin
    if (go && !rst && !fault && s_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  end
endmodule

// File: doc/data_memory_hs.md
Name: data_memory_hs

Overview:
- Parametrised, handshaked successor to the single-cycle data memory in the RV32 core.
- Accepts one load/store request at a time over a valid/ready interface and applies RV32I funct3 byte, half and word semantics with sign or zero extension.
- Inserts a configurable number of wait states and returns a registered response with a fault flag for misaligned, illegal or out-of-range accesses.
- Sits between the MEM stage and the backing store. The core's MEM stage stalls on req_ready/resp_valid.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of 2, 2..65536.
- WAIT_STATES, 0, extra cycles between accept and memory access; 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request this cycle
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-order bytes used for sb/sh
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result; 0 for stores and faults
- resp_fault  out  1  access rejected; memory unchanged

Behaviour:
- Reset: synchronous active-high on clk. Outputs/state after reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0. Memory array is not cleared.
- FSM states IDLE, WAIT, RESP.
  - req_ready=1 in IDLE and RESP, 0 in WAIT.
  - Accept = req_valid & req_ready. On accept, latch we/funct3/addr/wdata and load wait counter with WAIT_STATES.
- Transitions:
  - From IDLE or RESP on accept: go to WAIT if WAIT_STATES>0, else go to RESP.
  - IDLE/RESP with no accept: go to IDLE.
  - WAIT: decrement counter; go to RESP when counter==1.
- Memory access (write commit / read sample) happens on the edge that enters RESP.
  - resp_valid=1 for exactly the RESP cycle.
  - Latency from accept edge to resp_valid = WAIT_STATES+1 cycles.
  - Back-to-back throughput is one request per WAIT_STATES+1 cycles. A request accepted in a RESP cycle is legal.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Byte lane = addr[1:0].
- Loads:
  - lb/lbu (000/100): byte at lane, sign/zero-extended.
  - lh/lhu (001/101): half at addr[1], sign/zero-extended.
  - lw (010): full word.
- Stores:
  - sb (000): writes only the addressed byte.
  - sh (001): writes only the addressed half.
  - sw (010): writes the full word.
  - Untouched bytes keep their values.
- Fault (resp_fault=1, resp_rdata=0, no write) when any of:
  - half access with addr[0]=1;
  - word access with addr[1:0]!=00;
  - store funct3 not in {000,001,010};
  - load funct3 in {011,110,111};
  - addr >= 4*DEPTH_WORDS (upper address bits nonzero).
- Successful store: resp_fault=0, resp_rdata=0.
- Response outputs are registered and hold their last value after resp_valid drops. The bench checks them only while resp_valid=1.
- Read-after-write: a load accepted in the RESP cycle of a store observes the committed store data.
- Request inputs are ignored when not accepted. Changes to inputs after accept have no effect.
- Reset mid-operation:
  - In WAIT, the pending request is discarded and its store is not committed.
  - Reset coinciding with the commit edge also suppresses the write (reset has priority).

Test Plan:
- Reset, WAIT_STATES=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> each resp_valid exactly one cycle after accept; rdata=0xDEADBEEF, fault=0.
- Byte/half lanes: after sw 0x11223344 @0x20, sb 0xAA @0x23 then lw @0x20 -> 0xAA223344. lb @0x23 -> 0xFFFFFFAA, lbu -> 0x000000AA, lh @0x22 -> 0xFFFFAA22, lhu -> 0x0000AA22.
- WAIT_STATES=3: accept at cycle 0 -> req_ready=0 in cycles 1-3, resp_valid in cycle 4. New request accepted in cycle 4 responds in cycle 8.
- Faults: lw @0x21, sh @0x33, load funct3=011, store funct3=100, lw @0x1000 (DEPTH_WORDS=1024) -> fault=1, rdata=0; subsequent lw confirms memory unchanged.
- Reset in WAIT (WAIT_STATES=2): sw 0x55 @0x40 accepted, rst pulsed next cycle -> no resp_valid; lw @0x40 returns prior contents, req_ready=1 right after reset.
- Back-to-back, WAIT_STATES=0: store then load to the same address accepted in consecutive cycles -> load returns new data; resp_valid high two consecutive cycles.
